// File: rtl/peak_frame_ctrl.sv
// peak_frame_ctrl: frame sequencer for the single-channel two-peak detector.
// Turns an upstream sample stream (valid/ready/last) into detector beats with a
// running bin index. It holds the detector in reset between frames, drains it
// after the last beat and latches its results into a valid/ready result register.
// Optional build macro PEAK_FRAME_TIMEOUT_EN adds a RUN inactivity timeout that
// aborts the frame without a result and raises the sticky err_timeout_o.
module peak_frame_ctrl #(
    parameter int unsigned VALUE_WIDTH    = 16,
    parameter int unsigned INDEX_WIDTH    = 12,
    parameter int unsigned MAX_LEN        = 4096,
    parameter int unsigned MIN_LEN        = 8,
    parameter int unsigned DRAIN_CYCLES   = 2
`ifdef PEAK_FRAME_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [VALUE_WIDTH-1:0] s_data_i,
    input  logic                   s_last_i,
    output logic                   det_aresetn_o,
    output logic                   det_valid_o,
    output logic                   det_last_o,
    output logic [VALUE_WIDTH-1:0] det_data_o,
    output logic [INDEX_WIDTH-1:0] det_index_o,
    input  logic [VALUE_WIDTH-1:0] det_peak1_i,
    input  logic [VALUE_WIDTH-1:0] det_peak2_i,
    input  logic [INDEX_WIDTH-1:0] det_index1_i,
    input  logic [INDEX_WIDTH-1:0] det_index2_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [VALUE_WIDTH-1:0] res_peak1_o,
    output logic [VALUE_WIDTH-1:0] res_peak2_o,
    output logic [INDEX_WIDTH-1:0] res_index1_o,
    output logic [INDEX_WIDTH-1:0] res_index2_o,
    output logic [INDEX_WIDTH:0]   res_len_o,
    output logic [1:0]             res_flags_o,
    output logic [15:0]            res_frame_cnt_o,
`ifdef PEAK_FRAME_TIMEOUT_EN
    output logic                   err_timeout_o,
`endif
    output logic                   err_overrun_o
);

    localparam int unsigned LenW   = INDEX_WIDTH + 1;
    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [LenW-1:0]   LastBeat  = LenW'(MAX_LEN - 1);
    localparam logic [LenW-1:0]   MinLen    = LenW'(MIN_LEN);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDrain,
        StLoad
    } state_e;

    state_e state_q, state_d;

    logic              beat;
    logic              end_beat;
    logic              abort;
    logic              load;
    logic [LenW-1:0]   cnt_q, cnt_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic              trunc_q, trunc_d;

    logic                   res_valid_q;
    logic [VALUE_WIDTH-1:0] res_peak1_q, res_peak2_q;
    logic [INDEX_WIDTH-1:0] res_index1_q, res_index2_q;
    logic [LenW-1:0]        res_len_q;
    logic [1:0]             res_flags_q;
    logic [15:0]            res_frame_cnt_q;
    logic                   err_overrun_q;

    // s_ready_o is 1 throughout RUN, so any valid beat in RUN is accepted.
    assign beat     = (state_q == StRun) & s_valid_i;
    assign end_beat = beat & (s_last_i | (cnt_q == LastBeat));
    assign load     = (state_q == StLoad);

`ifdef PEAK_FRAME_TIMEOUT_EN
    localparam int unsigned    ToW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

    logic [ToW-1:0] idle_q, idle_d;
    logic           err_timeout_q;

    // Abort on the cycle that would make TIMEOUT_CYCLES consecutive beatless cycles.
    assign abort = (state_q == StRun) & ~s_valid_i & (idle_q == ToLast);

    // Consecutive beatless cycles while in RUN.
    always_comb begin
        idle_d = idle_q;
        if (state_q != StRun || beat) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Inactivity counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q        <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            idle_q <= idle_d;
            if (abort) begin
                err_timeout_q <= 1'b1;
            end
        end
    end

    assign err_timeout_o = err_timeout_q;
`else
    assign abort = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable_i) state_d = StClear;
            StClear: state_d = StRun;
            StRun: begin
                if (abort) begin
                    state_d = StClear;
                end else if (end_beat) begin
                    state_d = StDrain;
                end
            end
            StDrain: if (drain_q == DrainLast) state_d = StLoad;
            StLoad:  state_d = enable_i ? StClear : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode: detector beats are a zero-latency pass-through in RUN.
    always_comb begin
        s_ready_o     = 1'b0;
        det_aresetn_o = 1'b0;
        det_valid_o   = 1'b0;
        det_last_o    = 1'b0;
        det_data_o    = '0;
        det_index_o   = '0;
        unique case (state_q)
            StRun: begin
                s_ready_o     = 1'b1;
                det_aresetn_o = 1'b1;
                det_valid_o   = s_valid_i;
                det_last_o    = end_beat;
                det_data_o    = s_valid_i ? s_data_i : '0;
                det_index_o   = cnt_q[INDEX_WIDTH-1:0];
            end
            // Detector stays out of reset so its results survive until LOAD.
            StDrain, StLoad: det_aresetn_o = 1'b1;
            default: ;
        endcase
    end

    // Next values for beat counter, drain counter and truncation flag.
    always_comb begin
        cnt_d   = cnt_q;
        drain_d = drain_q;
        trunc_d = trunc_q;
        unique case (state_q)
            StClear: begin
                cnt_d   = '0;
                trunc_d = 1'b0;
            end
            StRun: begin
                drain_d = '0;
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (end_beat) begin
                    trunc_d = ~s_last_i;
                end
            end
            StDrain: drain_d = drain_q + 1'b1;
            default: ;
        endcase
    end

    // Frame bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            drain_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            trunc_q <= trunc_d;
        end
    end

    // Result register; a LOAD takes priority over a same-cycle consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q     <= 1'b0;
            res_peak1_q     <= '0;
            res_peak2_q     <= '0;
            res_index1_q    <= '0;
            res_index2_q    <= '0;
            res_len_q       <= '0;
            res_flags_q     <= '0;
            res_frame_cnt_q <= '0;
            err_overrun_q   <= 1'b0;
        end else if (load) begin
            res_valid_q     <= 1'b1;
            res_peak1_q     <= det_peak1_i;
            res_peak2_q     <= det_peak2_i;
            res_index1_q    <= det_index1_i;
            res_index2_q    <= det_index2_i;
            res_len_q       <= cnt_q;
            res_flags_q     <= {trunc_q, (cnt_q < MinLen)};
            res_frame_cnt_q <= res_frame_cnt_q + 16'd1;
            if (res_valid_q && !res_ready_i) begin
                err_overrun_q <= 1'b1;
            end
        end else if (res_valid_q && res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid_o     = res_valid_q;
    assign res_peak1_o     = res_peak1_q;
    assign res_peak2_o     = res_peak2_q;
    assign res_index1_o    = res_index1_q;
    assign res_index2_o    = res_index2_q;
    assign res_len_o       = res_len_q;
    assign res_flags_o     = res_flags_q;
    assign res_frame_cnt_o = res_frame_cnt_q;
    assign err_overrun_o   = err_overrun_q;

endmodule

// File: tb/tb_peak_frame_ctrl.sv
// tb_peak_frame_ctrl: directed plus randomized frames against a frame-level model.
// A behavioural stand-in detector reports max/argmax as peak1/index1 and the most
// recent beat as peak2/index2; the bench predicts both from the samples it sent.
module tb_peak_frame_ctrl;

    localparam int unsigned VW    = 16;
    localparam int unsigned IW    = 12;
    localparam int unsigned MAXL  = 32;
    localparam int unsigned MINL  = 8;
    localparam int unsigned DRAIN = 2;
    localparam int unsigned TO    = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic [VW-1:0] s_data = '0;
    logic          res_ready = 1'b0;

    logic          s_ready, det_aresetn, det_valid, det_last;
    logic [VW-1:0] det_data;
    logic [IW-1:0] det_index;
    logic [VW-1:0] fd_p1, fd_p2;
    logic [IW-1:0] fd_i1, fd_i2;
    logic          res_valid;
    logic [VW-1:0] res_peak1, res_peak2;
    logic [IW-1:0] res_index1, res_index2;
    logic [IW:0]   res_len;
    logic [1:0]    res_flags;
    logic [15:0]   res_frame_cnt;
    logic          err_overrun;
`ifdef PEAK_FRAME_TIMEOUT_EN
    logic          err_timeout;
`endif

    peak_frame_ctrl #(
        .VALUE_WIDTH   (VW),
        .INDEX_WIDTH   (IW),
        .MAX_LEN       (MAXL),
        .MIN_LEN       (MINL),
        .DRAIN_CYCLES  (DRAIN)
`ifdef PEAK_FRAME_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable_i       (enable),
        .s_valid_i      (s_valid),
        .s_ready_o      (s_ready),
        .s_data_i       (s_data),
        .s_last_i       (s_last),
        .det_aresetn_o  (det_aresetn),
        .det_valid_o    (det_valid),
        .det_last_o     (det_last),
        .det_data_o     (det_data),
        .det_index_o    (det_index),
        .det_peak1_i    (fd_p1),
        .det_peak2_i    (fd_p2),
        .det_index1_i   (fd_i1),
        .det_index2_i   (fd_i2),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_peak1_o    (res_peak1),
        .res_peak2_o    (res_peak2),
        .res_index1_o   (res_index1),
        .res_index2_o   (res_index2),
        .res_len_o      (res_len),
        .res_flags_o    (res_flags),
        .res_frame_cnt_o(res_frame_cnt),
`ifdef PEAK_FRAME_TIMEOUT_EN
        .err_timeout_o  (err_timeout),
`endif
        .err_overrun_o  (err_overrun)
    );

    always #5 clk = ~clk;

    // Stand-in detector: running max/argmax and most recent beat.
    always_ff @(posedge clk) begin
        if (!det_aresetn) begin
            fd_p1 <= '0;
            fd_i1 <= '0;
            fd_p2 <= '0;
            fd_i2 <= '0;
        end else if (det_valid) begin
            if (det_data > fd_p1) begin
                fd_p1 <= det_data;
                fd_i1 <= det_index;
            end
            fd_p2 <= det_data;
            fd_i2 <= det_index;
        end
    end

    int vectors = 0;
    int fails   = 0;
    int exp_cnt = 0;
    bit exp_ovr = 1'b0;
    bit pending = 1'b0;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_run(input int exp_wait);
        int w;
        w = 0;
        while (s_ready !== 1'b1 && w < 50) begin
            cycle();
            w++;
        end
        chk("run_entry", {31'd0, s_ready}, 32'd1);
        if (exp_wait >= 0) chk("run_wait", w, exp_wait);
    endtask

    // One frame of len beats (len > MAXL forces truncation); enable drops at beat drop_at.
    task automatic run_frame(input int len, input int drop_at, input bit rr, input bit fixed,
                             input int gapmax, input int exp_wait);
        int          n, w, i1;
        bit          trunc;
        logic [VW-1:0] d, p1;
        logic [1:0]  ef;
        res_ready = rr;
        if (rr) pending = 1'b0;
        n     = (len > int'(MAXL)) ? int'(MAXL) : len;
        trunc = (len > int'(MAXL));
        wait_run(exp_wait);
        p1 = '0;
        i1 = 0;
        d  = '0;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, gapmax)) begin
                s_valid = 1'b0;
                @(negedge clk);
                chk("idle_det_valid", {31'd0, det_valid}, 32'd0);
                cycle();
            end
            if (k == drop_at) enable = 1'b0;
            d       = fixed ? ((k == 2) ? VW'(90) : VW'(10 * (k + 1))) : VW'($urandom);
            s_valid = 1'b1;
            s_data  = d;
            s_last  = (!trunc && k == n - 1);
            @(negedge clk);
            chk("det_valid", {31'd0, det_valid}, 32'd1);
            chk("det_data", {16'd0, det_data}, {16'd0, d});
            chk("det_index", {20'd0, det_index}, k);
            chk("det_last", {31'd0, det_last}, {31'd0, (k == n - 1)});
            if (d > p1) begin
                p1 = d;
                i1 = k;
            end
            cycle();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        exp_cnt++;
        if (pending && !rr) exp_ovr = 1'b1;
        w = 0;
        while (res_frame_cnt !== 16'(exp_cnt) && w < 20) begin
            cycle();
            w++;
        end
        chk("res_latency", w, DRAIN + 1);
        ef = {trunc, (n < int'(MINL))};
        chk("res_valid", {31'd0, res_valid}, 32'd1);
        chk("res_len", {19'd0, res_len}, n);
        chk("res_flags", {30'd0, res_flags}, {30'd0, ef});
        chk("res_frame_cnt", {16'd0, res_frame_cnt}, {16'd0, 16'(exp_cnt)});
        chk("res_peak1", {16'd0, res_peak1}, {16'd0, p1});
        chk("res_index1", {20'd0, res_index1}, i1);
        chk("res_peak2", {16'd0, res_peak2}, {16'd0, d});
        chk("res_index2", {20'd0, res_index2}, n - 1);
        chk("err_overrun", {31'd0, err_overrun}, {31'd0, exp_ovr});
        chk("gap_s_ready", {31'd0, s_ready}, 32'd0);
        chk("gap_det_aresetn", {31'd0, det_aresetn}, 32'd0);
        pending = 1'b1;
        if (rr) begin
            cycle();
            chk("res_consumed", {31'd0, res_valid}, 32'd0);
            pending = 1'b0;
            if (enable) chk("next_run", {31'd0, s_ready}, 32'd1);
        end
    endtask

    initial begin
        // Reset values.
        repeat (2) cycle();
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_det_aresetn", {31'd0, det_aresetn}, 32'd0);
        chk("rst_det_valid", {31'd0, det_valid}, 32'd0);
        chk("rst_det_index", {20'd0, det_index}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_len", {19'd0, res_len}, 32'd0);
        chk("rst_frame_cnt", {16'd0, res_frame_cnt}, 32'd0);
        chk("rst_err_overrun", {31'd0, err_overrun}, 32'd0);
        reset = 1'b0;
        cycle();
        chk("idle_hold", {31'd0, s_ready}, 32'd0);
        enable = 1'b1;

        // 16-beat frame with known data, result consumed.
        run_frame(16, -1, 1'b1, 1'b1, 0, 2);

        // Back-to-back unread results overwrite and raise err_overrun.
        run_frame(10, -1, 1'b0, 1'b0, 1, 0);
        run_frame(12, -1, 1'b0, 1'b0, 0, 1);
        res_ready = 1'b1;
        cycle();
        chk("ovr_consumed", {31'd0, res_valid}, 32'd0);
        pending = 1'b0;

        // Short-frame boundary and truncation boundary.
        run_frame(5, -1, 1'b1, 1'b0, 2, -1);
        run_frame(7, -1, 1'b1, 1'b0, 0, 0);
        run_frame(8, -1, 1'b1, 1'b0, 0, 0);
        run_frame(40, -1, 1'b1, 1'b0, 1, 0);
        run_frame(32, -1, 1'b1, 1'b0, 0, 0);

        // Dropping enable mid-frame completes the frame, then parks in IDLE.
        run_frame(12, 4, 1'b0, 1'b0, 1, 0);
        repeat (2) cycle();
        chk("idle_s_ready", {31'd0, s_ready}, 32'd0);
        chk("idle_det_aresetn", {31'd0, det_aresetn}, 32'd0);
        chk("idle_res_valid", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        cycle();
        chk("idle_consumed", {31'd0, res_valid}, 32'd0);
        pending = 1'b0;
        enable  = 1'b1;

        // Overrun is set; reset at beat 7 of a frame discards it and clears everything.
        run_frame(9, -1, 1'b0, 1'b0, 0, 2);
        run_frame(9, -1, 1'b0, 1'b0, 0, 1);
        chk("pre_rst_overrun", {31'd0, err_overrun}, 32'd1);
        res_ready = 1'b0;
        wait_run(-1);
        for (int k = 0; k < 7; k++) begin
            s_valid = 1'b1;
            s_data  = VW'($urandom);
            cycle();
        end
        s_data = VW'($urandom);
        reset  = 1'b1;
        cycle();
        reset   = 1'b0;
        s_valid = 1'b0;
        exp_cnt = 0;
        exp_ovr = 1'b0;
        pending = 1'b0;
        chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("mid_rst_det_aresetn", {31'd0, det_aresetn}, 32'd0);
        chk("mid_rst_det_index", {20'd0, det_index}, 32'd0);
        chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_rst_frame_cnt", {16'd0, res_frame_cnt}, 32'd0);
        chk("mid_rst_overrun", {31'd0, err_overrun}, 32'd0);

        // Randomized frames.
        run_frame(6, -1, 1'b1, 1'b0, 1, 2);
        for (int f = 0; f < 8; f++) begin
            run_frame($urandom_range(1, 40), -1, ($urandom_range(0, 3) != 0), 1'b0, 3, -1);
        end
        res_ready = 1'b1;
        run_frame(3, -1, 1'b1, 1'b0, 0, -1);

`ifdef PEAK_FRAME_TIMEOUT_EN
        // Stall TO cycles in RUN: abort to CLEAR, no result, sticky flag.
        wait_run(0);
        repeat (TO - 1) cycle();
        chk("to_not_yet", {31'd0, err_timeout}, 32'd0);
        chk("to_still_run", {31'd0, s_ready}, 32'd1);
        cycle();
        chk("to_flag", {31'd0, err_timeout}, 32'd1);
        chk("to_clear", {31'd0, det_aresetn}, 32'd0);
        repeat (4) cycle();
        chk("to_no_result", {31'd0, res_valid}, 32'd0);
        chk("to_frame_cnt", {16'd0, res_frame_cnt}, {16'd0, 16'(exp_cnt)});
        run_frame(4, -1, 1'b1, 1'b0, 0, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
